// File: rtl/iommu_intr_ctrl.sv
// -----------------------------------------------------------------------------
// iommu_intr_ctrl
//   Interrupt pending/dispatch controller for the IOMMU event sources
//   (CQ, FQ, HPM, PQ). Keeps the IPSR pending bits (hardware set, software
//   write-1-to-clear), maps every source onto a vector through its ivec field
//   and either drives wired interrupt lines (WSI) or hands MSI requests to the
//   MSI write engine one at a time over a req/ack handshake, round-robin
//   between sources.
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   msi_en_i   1 = MSI mode, 0 = wired (WSI) mode
//   src_evt_i  single-cycle event pulses, one per source
//   src_ie_i   per-source interrupt enable
//   ivec_i     vector of source k at [k*VEC_W +: VEC_W]
//   sw_we_i    software write strobe to IPSR
//   sw_wd_i    software write data, write-1-to-clear
//   ipsr_o     IPSR pending bits
//   wsi_o      wired interrupt lines (registered)
//   msi_req_o  MSI request to the write engine
//   msi_vec_o  vector of the current MSI request
//   msi_ack_i  MSI engine accepts the request
// -----------------------------------------------------------------------------
module iommu_intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int N_VEC = 16,
    parameter int VEC_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   msi_en_i,
    input  logic [N_SRC-1:0]       src_evt_i,
    input  logic [N_SRC-1:0]       src_ie_i,
    input  logic [N_SRC*VEC_W-1:0] ivec_i,
    input  logic                   sw_we_i,
    input  logic [N_SRC-1:0]       sw_wd_i,
    output logic [N_SRC-1:0]       ipsr_o,
    output logic [N_VEC-1:0]       wsi_o,
    output logic                   msi_req_o,
    output logic [VEC_W-1:0]       msi_vec_o,
    input  logic                   msi_ack_i
);

    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [SEL_W:0] N_SRC_EXT = (SEL_W+1)'(N_SRC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // State
    logic [N_SRC-1:0] ipsr_reg,  ipsr_next;
    logic [N_VEC-1:0] wsi_reg,   wsi_next;
    logic             req_reg,   req_next;
    logic [VEC_W-1:0] vec_reg,   vec_next;
    logic [N_SRC-1:0] pend_reg,  pend_next;
    logic             again_reg, again_next;  // in-flight source re-pended
    logic [SEL_W-1:0] sel_reg,   sel_next;
    logic [SEL_W-1:0] rr_reg,    rr_next;
    logic [0:0]       state_reg, state_next;

    logic [VEC_W-1:0] ivec_arr [N_SRC];
    logic [N_SRC-1:0] ev_set;
    logic [N_SRC-1:0] ev_clr;
    logic [N_SRC-1:0] rose;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W:0]   scan_idx;

    genvar gi;

    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_ivec
            assign ivec_arr[gi] = ivec_i[gi*VEC_W +: VEC_W];
        end
    endgenerate

    // IPSR: an event wins over a simultaneous software clear so it is never lost.
    assign ev_set    = src_evt_i & src_ie_i;
    assign ev_clr    = {N_SRC{sw_we_i}} & sw_wd_i;
    assign ipsr_next = ev_set | (ipsr_reg & ~ev_clr);

    // A 0->1 transition of an IPSR bit in MSI mode is what makes an MSI pending.
    assign rose = ipsr_next & ~ipsr_reg & {N_SRC{msi_en_i}};

    // Wired lines follow the registered IPSR with one cycle of latency. Only
    // vector numbers 0..N_VEC-1 are compared, so out-of-range ivec values
    // naturally drive no line.
    generate
        for (gi = 0; gi < N_VEC; gi++) begin : g_wsi
            logic [N_SRC-1:0] vec_hit;
            always_comb begin
                vec_hit = '0;
                for (int k = 0; k < N_SRC; k++) begin
                    vec_hit[k] = (ivec_arr[k] == VEC_W'(gi));
                end
            end
            assign wsi_next[gi] = !msi_en_i && |(ipsr_reg & vec_hit);
        end
    endgenerate

    // Round-robin pick: first pending source at or above rr_reg, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_reg;
        scan_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            scan_idx = {1'b0, rr_reg} + (SEL_W+1)'(i);
            if (scan_idx >= N_SRC_EXT) begin
                scan_idx = scan_idx - N_SRC_EXT;
            end
            if (!pick_found && pend_reg[scan_idx[SEL_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[SEL_W-1:0];
            end
        end
    end

    // Dispatch FSM. Outside MSI mode every pending bit is dropped except the
    // one already in flight; an issued request always runs to its ack.
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        vec_next   = vec_reg;
        sel_next   = sel_reg;
        rr_next    = rr_reg;
        again_next = again_reg;
        pend_next  = msi_en_i ? (pend_reg | rose) : '0;

        if (state_reg == ST_IDLE) begin
            // Ack is ignored here.
            if (msi_en_i && pick_found) begin
                state_next = ST_REQ;
                req_next   = 1'b1;
                sel_next   = pick_idx;
                vec_next   = ivec_arr[pick_idx];
                again_next = rose[pick_idx];
            end
        end else begin
            pend_next[sel_reg] = pend_reg[sel_reg];
            if (msi_ack_i) begin
                // A re-pend seen while in flight keeps the bit set for a resend.
                pend_next[sel_reg] = (again_reg & msi_en_i) | rose[sel_reg];
                state_next         = ST_IDLE;
                req_next           = 1'b0;
                again_next         = 1'b0;
                rr_next            = (sel_reg == SEL_W'(N_SRC - 1)) ? '0 : sel_reg + 1'b1;
            end else begin
                again_next = msi_en_i & (again_reg | rose[sel_reg]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ipsr_reg  <= '0;
            wsi_reg   <= '0;
            req_reg   <= 1'b0;
            vec_reg   <= '0;
            pend_reg  <= '0;
            again_reg <= 1'b0;
            sel_reg   <= '0;
            rr_reg    <= '0;
            state_reg <= ST_IDLE;
        end else begin
            ipsr_reg  <= ipsr_next;
            wsi_reg   <= wsi_next;
            req_reg   <= req_next;
            vec_reg   <= vec_next;
            pend_reg  <= pend_next;
            again_reg <= again_next;
            sel_reg   <= sel_next;
            rr_reg    <= rr_next;
            state_reg <= state_next;
        end
    end

    assign ipsr_o    = ipsr_reg;
    assign wsi_o     = wsi_reg;
    assign msi_req_o = req_reg;
    assign msi_vec_o = vec_reg;

endmodule
